// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-port arbiter/sequencer in front of a byte-addressed data memory
// (async read, write on posedge). Port 0 is the core load/store unit, port 1
// the debug/DMA master. One access is in flight at a time and every access
// takes exactly three cycles: grant (IDLE) -> memory strobe (ACCESS) ->
// response pulse (RESP).
//
// Parameters
//   MEM_BYTES  memory size in bytes; accesses with addr+size > MEM_BYTES fail
//   RR_EN      1 = round-robin on contest, 0 = fixed priority (port 0 wins)
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   reqN_valid/ready            request handshake (N = 0,1); ready is
//                               combinational in IDLE only
//   reqN_we/addr/wdata/funct3   request payload (RV32I size code)
//   rspN_valid/rdata/err        one-cycle response to the granted port
//   mem_read/write/addr/wdata/funct3  memory strobes, high for one cycle
//   mem_rdata                   combinational read data from memory
//
// Configuration macro
//   DMEM_ALIGN_CHECK_EN  when defined, misaligned halfword/word accesses are
//                        rejected with err=1 and never reach the memory.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned RR_EN     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [2:0]  req0_funct3,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [2:0]  req1_funct3,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_grant;
  logic        r_port;
  logic        r_err;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [2:0]  r_mem_funct3;
  logic        r_rsp0_valid;
  logic        r_rsp1_valid;
  logic [31:0] r_rsp0_rdata;
  logic [31:0] r_rsp1_rdata;
  logic        r_rsp0_err;
  logic        r_rsp1_err;

  logic        w_grant;
  logic        w_pick1;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [2:0]  w_sel_funct3;
  logic        w_sel_err;

  // Decide whether a request must be rejected: bad size code, sign-extending
  // store code, range overflow (33-bit sum so high addresses cannot wrap)
  // and, when enabled, natural alignment.
  function automatic logic access_err(input logic        we,
                                      input logic [31:0] addr,
                                      input logic [2:0]  f3);
    logic [32:0] size;
    logic        bad;
    bad = 1'b0;
    case (f3)
      3'b000, 3'b100: size = 33'd1;
      3'b001, 3'b101: size = 33'd2;
      3'b010:         size = 33'd4;
      default: begin
        size = 33'd0;
        bad  = 1'b1;
      end
    endcase
    if (we && f3[2]) bad = 1'b1;
    if (({1'b0, addr} + size) > 33'(MEM_BYTES)) bad = 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
    if ((f3[1:0] == 2'b01) && addr[0]) bad = 1'b1;
    if ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00)) bad = 1'b1;
`endif
    return bad;
  endfunction

  // Winner selection and payload mux. last_grant resets to 1 so port 0 wins
  // the first contested slot.
  always_comb begin
    w_pick1 = 1'b0;
    if (req1_valid) begin
      if (!req0_valid) begin
        w_pick1 = 1'b1;
      end else if ((RR_EN != 0) && !r_last_grant) begin
        w_pick1 = 1'b1;
      end else begin
        w_pick1 = 1'b0;
      end
    end else begin
      w_pick1 = 1'b0;
    end
    w_sel_we     = w_pick1 ? req1_we     : req0_we;
    w_sel_addr   = w_pick1 ? req1_addr   : req0_addr;
    w_sel_wdata  = w_pick1 ? req1_wdata  : req0_wdata;
    w_sel_funct3 = w_pick1 ? req1_funct3 : req0_funct3;
    w_sel_err    = access_err(w_sel_we, w_sel_addr, w_sel_funct3);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and request-ready decode; ready only ever asserts in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          w_grant     = 1'b1;
          req0_ready  = !w_pick1;
          req1_ready  = w_pick1;
          w_state_nxt = ST_ACCESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: w_state_nxt = ST_RESP;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: memory strobes are loaded on the grant edge so they are high
  // for exactly the ACCESS cycle; the response is loaded on the ACCESS edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_err        <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_mem_funct3 <= 3'd0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_rdata <= 32'd0;
      r_rsp1_rdata <= 32'd0;
      r_rsp0_err   <= 1'b0;
      r_rsp1_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_last_grant <= w_pick1;
            r_port       <= w_pick1;
            r_err        <= w_sel_err;
            // Rejected requests never touch the memory bus.
            r_mem_read   <= !w_sel_we && !w_sel_err;
            r_mem_write  <= w_sel_we && !w_sel_err;
            r_mem_addr   <= w_sel_err ? 32'd0 : w_sel_addr;
            r_mem_wdata  <= (w_sel_err || !w_sel_we) ? 32'd0 : w_sel_wdata;
            r_mem_funct3 <= w_sel_err ? 3'd0 : w_sel_funct3;
          end
        end
        ST_ACCESS: begin
          r_mem_read   <= 1'b0;
          r_mem_write  <= 1'b0;
          r_mem_addr   <= 32'd0;
          r_mem_wdata  <= 32'd0;
          r_mem_funct3 <= 3'd0;
          r_rsp0_valid <= !r_port;
          r_rsp1_valid <= r_port;
          r_rsp0_rdata <= (!r_port && r_mem_read) ? mem_rdata : 32'd0;
          r_rsp1_rdata <= (r_port && r_mem_read) ? mem_rdata : 32'd0;
          r_rsp0_err   <= !r_port && r_err;
          r_rsp1_err   <= r_port && r_err;
        end
        default: begin
          r_rsp0_valid <= 1'b0;
          r_rsp1_valid <= 1'b0;
          r_rsp0_rdata <= 32'd0;
          r_rsp1_rdata <= 32'd0;
          r_rsp0_err   <= 1'b0;
          r_rsp1_err   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_funct3 = r_mem_funct3;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_rdata = r_rsp0_rdata;
  assign rsp1_rdata = r_rsp1_rdata;
  assign rsp0_err   = r_rsp0_err;
  assign rsp1_err   = r_rsp1_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter. A small byte-array memory model
// (async read with RV32I load extension, write on posedge) sits behind the
// round-robin instance; a second fixed-priority instance shares the request
// inputs for the arbitration comparison.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_we, req1_valid, req1_we;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic [2:0]  req0_funct3, req1_funct3;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_funct3;

  logic        f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid, f_rsp0_err, f_rsp1_err;
  logic [31:0] f_rsp0_rdata, f_rsp1_rdata;
  logic        f_mem_read, f_mem_write;
  logic [31:0] f_mem_addr, f_mem_wdata;
  logic [2:0]  f_mem_funct3;

  logic        mem_init;
  logic [7:0]  mem [0:1023];
  int          checks = 0;
  int          failures = 0;

  dmem_arbiter #(.MEM_BYTES(1024), .RR_EN(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_funct3(req0_funct3),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_funct3(req1_funct3),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.MEM_BYTES(1024), .RR_EN(0)) u_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_funct3(req0_funct3),
    .rsp0_valid(f_rsp0_valid), .rsp0_rdata(f_rsp0_rdata), .rsp0_err(f_rsp0_err),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_funct3(req1_funct3),
    .rsp1_valid(f_rsp1_valid), .rsp1_rdata(f_rsp1_rdata), .rsp1_err(f_rsp1_err),
    .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_addr(f_mem_addr),
    .mem_wdata(f_mem_wdata), .mem_funct3(f_mem_funct3), .mem_rdata(32'd0)
  );

  always #5 clk = ~clk;

  // Memory model write port (also loads the initial image).
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[16] <= 8'hEF;
      mem[17] <= 8'hBE;
      mem[18] <= 8'hAD;
      mem[19] <= 8'hDE;
    end else if (mem_write) begin
      mem[mem_addr[9:0]] <= mem_wdata[7:0];
      if (mem_funct3[1:0] != 2'b00) mem[mem_addr[9:0] + 10'd1] <= mem_wdata[15:8];
      if (mem_funct3[1:0] == 2'b10) begin
        mem[mem_addr[9:0] + 10'd2] <= mem_wdata[23:16];
        mem[mem_addr[9:0] + 10'd3] <= mem_wdata[31:24];
      end
    end
  end

  // Memory model read port, little-endian with load extension.
  always_comb begin
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[mem_addr[9:0]];
    b1 = mem[mem_addr[9:0] + 10'd1];
    b2 = mem[mem_addr[9:0] + 10'd2];
    b3 = mem[mem_addr[9:0] + 10'd3];
    case (mem_funct3)
      3'b000:  mem_rdata = {{24{b0[7]}}, b0};
      3'b100:  mem_rdata = {24'd0, b0};
      3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
      3'b101:  mem_rdata = {16'd0, b1, b0};
      3'b010:  mem_rdata = {b3, b2, b1, b0};
      default: mem_rdata = 32'd0;
    endcase
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] f3, input logic e, input logic [31:0] rd);
    vec_t v;
    v.port = p; v.we = we; v.addr = a; v.wdata = wd; v.f3 = f3; v.err = e; v.rdata = rd;
    vecs.push_back(v);
  endtask

  task automatic clear_reqs();
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 32'd0; req0_wdata = 32'd0; req0_funct3 = 3'd0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 32'd0; req1_wdata = 32'd0; req1_funct3 = 3'd0;
  endtask

  task automatic drive(input logic p, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3);
    if (p) begin
      req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = wd; req1_funct3 = f3;
    end else begin
      req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = wd; req0_funct3 = f3;
    end
  endtask

  // One transaction, entered just after a posedge with the DUT in IDLE.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    logic  acc;
    tag = $sformatf("v%0d", idx);
    acc = !v.err;
    drive(v.port, v.we, v.addr, v.wdata, v.f3);
    @(negedge clk);
    check({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, v.port ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    clear_reqs();
    @(negedge clk);
    check({tag, "_mem_rw"}, {30'd0, mem_write, mem_read}, {30'd0, v.we && acc, !v.we && acc});
    if (acc) begin
      check({tag, "_mem_addr"}, mem_addr, v.addr);
      check({tag, "_mem_f3"}, {29'd0, mem_funct3}, {29'd0, v.f3});
      if (v.we) check({tag, "_mem_wdata"}, mem_wdata, v.wdata);
    end
    @(negedge clk);
    check({tag, "_rsp_valid"}, {30'd0, rsp1_valid, rsp0_valid}, v.port ? 32'd2 : 32'd1);
    check({tag, "_rdata"}, v.port ? rsp1_rdata : rsp0_rdata, v.rdata);
    check({tag, "_err"}, {31'd0, v.port ? rsp1_err : rsp0_err}, {31'd0, v.err});
    check({tag, "_mem_idle"}, {30'd0, mem_write, mem_read}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic align;
`ifdef DMEM_ALIGN_CHECK_EN
    align = 1'b1;
`else
    align = 1'b0;
`endif
    // port, we, addr, wdata, funct3, err, rdata
    add(1'b0, 1'b0, 32'h10,  32'd0,        3'b010, 1'b0, 32'hDEADBEEF);
    add(1'b1, 1'b1, 32'h3,   32'h000000A5, 3'b000, 1'b0, 32'd0);
    add(1'b1, 1'b0, 32'h3,   32'd0,        3'b100, 1'b0, 32'h000000A5);
    add(1'b1, 1'b0, 32'h3,   32'd0,        3'b000, 1'b0, 32'hFFFFFFA5);
    add(1'b0, 1'b0, 32'h3FE, 32'd0,        3'b010, 1'b1, 32'd0);
    add(1'b0, 1'b1, 32'h3FC, 32'h12345678, 3'b010, 1'b0, 32'd0);
    add(1'b1, 1'b0, 32'h3FC, 32'd0,        3'b010, 1'b0, 32'h12345678);
    add(1'b0, 1'b1, 32'h3FF, 32'h00000077, 3'b000, 1'b0, 32'd0);
    add(1'b0, 1'b0, 32'h3FF, 32'd0,        3'b100, 1'b0, 32'h00000077);
    add(1'b0, 1'b0, 32'h3FF, 32'd0,        3'b001, 1'b1, 32'd0);
    add(1'b1, 1'b0, 32'h10,  32'd0,        3'b011, 1'b1, 32'd0);
    add(1'b0, 1'b1, 32'h20,  32'h11,       3'b100, 1'b1, 32'd0);
    add(1'b0, 1'b0, 32'hFFFFFFFC, 32'd0,   3'b010, 1'b1, 32'd0);
    add(1'b0, 1'b0, 32'h10,  32'd0,        3'b001, 1'b0, 32'hFFFFBEEF);
    add(1'b1, 1'b0, 32'h12,  32'd0,        3'b101, 1'b0, 32'h0000DEAD);
    add(1'b0, 1'b1, 32'h5,   32'h0000BEEF, 3'b001, align, 32'd0);
    add(1'b0, 1'b0, 32'h5,   32'd0,        3'b100, 1'b0, align ? 32'd0 : 32'h000000EF);
    add(1'b0, 1'b0, 32'h6,   32'd0,        3'b100, 1'b0, align ? 32'd0 : 32'h000000BE);
    add(1'b1, 1'b0, 32'h5,   32'd0,        3'b101, align, align ? 32'd0 : 32'h0000BEEF);
    add(1'b0, 1'b0, 32'h0,   32'd0,        3'b110, 1'b1, 32'd0);

    clear_reqs();
    rst = 1'b1;
    mem_init = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {26'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_read, mem_write}, 32'd0);
    check("reset_addr", mem_addr, 32'd0);
    check("reset_rdata", rsp0_rdata | rsp1_rdata, 32'd0);
    mem_init = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_ctrl", {28'd0, rsp0_valid, rsp1_valid, mem_read, mem_write}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset during the ACCESS cycle of a store: nothing written, no response.
    drive(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 3'b010);
    @(negedge clk);
    check("rst_seq_ready", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    clear_reqs();
    check("rst_seq_access", {31'd0, mem_write}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_seq_drop", {30'd0, mem_write, mem_read}, 32'd0);
    @(posedge clk); #1;
    check("rst_seq_norsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check("rst_seq_outs", mem_addr | mem_wdata | rsp0_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_seq_mem", {mem[32], mem[33], mem[34], mem[35]}, 32'd0);

    // Both ports valid continuously: RR alternates, fixed priority keeps port 0.
    drive(1'b0, 1'b0, 32'h10, 32'd0, 3'b010);
    drive(1'b1, 1'b0, 32'h10, 32'd0, 3'b010);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("rr_c%0d", c), {30'd0, req1_ready, req0_ready},
            (c % 3 != 0) ? 32'd0 : (((c / 3) % 2 == 0) ? 32'd1 : 32'd2));
      check($sformatf("fp_c%0d", c), {30'd0, f_req1_ready, f_req0_ready},
            (c % 3 != 0) ? 32'd0 : 32'd1);
      @(posedge clk); #1;
    end
    clear_reqs();
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
